dds_pulse_sequencer: RTL and testbench

//  Radar pulse timing controller driving the DDS modulator. Latches PRI, pulse-width and

---
 rtl/dds_pulse_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dds_pulse_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dds_pulse_sequencer.sv
// Radar pulse timing controller: latches PRI / pulse width / pulse count on start and
// sequences DDS phase reset, TX enable and RX listen gates, one PRI at a time.
module dds_pulse_sequencer #(
   parameter int CNT_W = 32,
   parameter int NP_W  = 16
) (
   input  logic             S_AXI_CLK,
   input  logic             S_AXI_ARESETN,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [CNT_W-1:0] pri_cycles_i,
   input  logic [CNT_W-1:0] pulse_cycles_i,
   input  logic [NP_W-1:0]  num_pulses_i,
   output logic             dds_phase_rst_o,
   output logic             dds_enable_o,
   output logic             rx_gate_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [NP_W-1:0]  pulse_idx_o,
   output logic             cfg_err_o
);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_ARM    = 5'b00010,
      S_PULSE  = 5'b00100,
      S_LISTEN = 5'b01000,
      S_DONE   = 5'b10000
   } state_t;

   localparam logic [CNT_W-1:0] C_CNT_ONE  = 1;
   localparam logic [CNT_W:0]   C_CNT_ONEX = 1;
   localparam logic [NP_W-1:0]  C_NP_ONE   = 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_pulse;
   logic [CNT_W-1:0] r_listen;
   logic [NP_W-1:0]  r_num;
   logic [NP_W-1:0]  r_idx;
   logic             r_stop;

   logic             r_phase_rst;
   logic             r_enable;
   logic             r_rx_gate;
   logic             r_busy;
   logic             r_done;
   logic [NP_W-1:0]  r_idx_out;
   logic             r_cfg_err;

   logic             w_cfg_bad;
   logic             w_start_req;
   logic             w_accept;
   logic             w_reject;
   logic             w_pulse_end;
   logic             w_listen_end;
   logic             w_pri_end;
   logic             w_burst_end;
   state_t           w_end_state;
   logic             w_phase_rst_next;
   logic             w_enable_next;
   logic             w_rx_gate_next;
   logic             w_busy_next;
   logic             w_done_next;

   // Compare in CNT_W+1 bits so pulse_cycles_i = all-ones cannot wrap to a passing value.
   assign w_cfg_bad    = (pulse_cycles_i == '0) ||
                         ({1'b0, pri_cycles_i} < ({1'b0, pulse_cycles_i} + C_CNT_ONEX));
   assign w_start_req  = (r_state == S_IDLE) && start_i && !stop_i;
   assign w_accept     = w_start_req && !w_cfg_bad;
   assign w_reject     = w_start_req && w_cfg_bad;

   assign w_pulse_end  = (r_cnt == r_pulse - C_CNT_ONE);
   assign w_listen_end = (r_cnt == r_listen - C_CNT_ONE);
   assign w_pri_end    = ((r_state == S_PULSE) && w_pulse_end && (r_listen == '0)) ||
                         ((r_state == S_LISTEN) && w_listen_end);
   // A stop arriving on the final cycle of the PRI still counts for that PRI.
   assign w_burst_end  = r_stop || stop_i ||
                         ((r_num != '0) && (r_idx == r_num - C_NP_ONE));
   assign w_end_state  = w_burst_end ? S_DONE : S_ARM;

   always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_next = S_ARM;
         S_ARM:    w_state_next = S_PULSE;
         S_PULSE:  if (w_pulse_end) w_state_next = (r_listen == '0) ? w_end_state : S_LISTEN;
         S_LISTEN: if (w_listen_end) w_state_next = w_end_state;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_phase_rst_next = (r_state == S_ARM);
      w_enable_next    = (r_state == S_PULSE);
      w_rx_gate_next   = (r_state == S_LISTEN);
      w_busy_next      = (r_state != S_IDLE);
      w_done_next      = (r_state == S_DONE);
   end

   // Per-state cycle counter restarts on every state change.
   always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_cnt     <= '0;
         r_pulse   <= '0;
         r_listen  <= '0;
         r_num     <= '0;
         r_idx     <= '0;
         r_stop    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + C_CNT_ONE;
         if (w_accept) begin
            r_pulse   <= pulse_cycles_i;
            r_listen  <= pri_cycles_i - pulse_cycles_i - C_CNT_ONE;
            r_num     <= num_pulses_i;
            r_idx     <= '0;
            r_cfg_err <= 1'b0;
         end else if (w_reject) begin
            r_cfg_err <= 1'b1;
         end else if (w_pri_end && !w_burst_end) begin
            r_idx <= r_idx + C_NP_ONE;
         end
         if (r_state == S_DONE) begin
            r_stop <= 1'b0;
         end else if ((r_state != S_IDLE) && stop_i) begin
            r_stop <= 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXI_CLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_phase_rst <= 1'b0;
         r_enable    <= 1'b0;
         r_rx_gate   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_idx_out   <= '0;
      end else begin
         r_phase_rst <= w_phase_rst_next;
         r_enable    <= w_enable_next;
         r_rx_gate   <= w_rx_gate_next;
         r_busy      <= w_busy_next;
         r_done      <= w_done_next;
         r_idx_out   <= r_idx;
      end
   end

   assign dds_phase_rst_o = r_phase_rst;
   assign dds_enable_o    = r_enable;
   assign rx_gate_o       = r_rx_gate;
   assign busy_o          = r_busy;
   assign done_o          = r_done;
   assign pulse_idx_o     = r_idx_out;
   assign cfg_err_o       = r_cfg_err;

endmodule

// File: tb/tb_dds_pulse_sequencer.sv
// Self-checking bench for dds_pulse_sequencer: per-cycle waveform model of each burst,
// a table of config-validation vectors, an async-reset sequence and random bursts.
module tb_dds_pulse_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] pri_in = '0;
   logic [31:0] pulse_in = '0;
   logic [15:0] num_in = '0;
   logic        phase_rst, enable, rx_gate, busy, done, cfg_err;
   logic [15:0] idx;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] prev_idx = '0;

   dds_pulse_sequencer #(.CNT_W(32), .NP_W(16)) dut (
      .S_AXI_CLK       (clk),
      .S_AXI_ARESETN   (rst_n),
      .start_i         (start),
      .stop_i          (stop),
      .pri_cycles_i    (pri_in),
      .pulse_cycles_i  (pulse_in),
      .num_pulses_i    (num_in),
      .dds_phase_rst_o (phase_rst),
      .dds_enable_o    (enable),
      .rx_gate_o       (rx_gate),
      .busy_o          (busy),
      .done_o          (done),
      .pulse_idx_o     (idx),
      .cfg_err_o       (cfg_err)
   );

   always #5 clk = ~clk;

   // Observed vector layout: {phase_rst, enable, rx_gate, busy, done, cfg_err, idx[15:0]}
   function automatic logic [21:0] obs();
      return {phase_rst, enable, rx_gate, busy, done, cfg_err, idx};
   endfunction

   task automatic check(input string name, input int k, input logic [21:0] exp_v);
      logic [21:0] got;
      got = obs();
      n_cmp++;
      if (got !== exp_v) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%h (ph,en,rx,busy,done,err,idx) required=%h", name, k, got, exp_v);
      end
   endtask

   // Expected outputs k cycles after the start edge for a burst of b PRIs:
   // PRI j spans cycles j*pri+1 .. (j+1)*pri; within it, offset 0 is the phase reset,
   // offsets 1..pulse are TX, the rest is listen. done follows the last PRI.
   function automatic logic [21:0] model(input int k, input int pri, input int pulse,
                                         input int b, input logic [15:0] idx0);
      logic ph, en, rx, bz, dn;
      logic [15:0] ix;
      int p;
      ph = 0; en = 0; rx = 0; bz = 0; dn = 0; ix = idx0;
      if (k >= 1 && k <= b * pri) begin
         p  = (k - 1) % pri;
         ph = (p == 0);
         en = (p >= 1) && (p <= pulse);
         rx = (p > pulse);
         bz = 1;
         ix = 16'((k - 1) / pri);
      end else if (k == b * pri + 1) begin
         bz = 1;
         dn = 1;
         ix = 16'(b - 1);
      end else if (k > b * pri + 1) begin
         ix = 16'(b - 1);
      end
      return {ph, en, rx, bz, dn, 1'b0, ix};
   endfunction

   // stop_c: cycle index at which stop is driven for one cycle (-1 = none).
   task automatic run_burst(input string name, input int pri, input int pulse, input int num,
                            input int stop_c, input bit scramble, input bit poke_start);
      int b;
      b = num;
      if (stop_c >= 0) begin
         if (num == 0 || stop_c / pri + 1 < b) b = stop_c / pri + 1;
      end
      @(negedge clk);
      pri_in = pri; pulse_in = pulse; num_in = 16'(num); start = 1; stop = 0;
      for (int k = 0; k <= b * pri + 2; k++) begin
         @(negedge clk);
         check(name, k, model(k, pri, pulse, b, prev_idx));
         start = poke_start && (k >= 1) && (k < b * pri) && ($urandom_range(0, 3) == 0);
         stop  = (k == stop_c);
         if (scramble) begin
            pri_in   = $urandom;
            pulse_in = $urandom_range(0, 40);
            num_in   = 16'($urandom_range(0, 3));
         end
      end
      start = 0;
      stop  = 0;
      prev_idx = 16'(b - 1);
   endtask

   typedef struct {
      logic [31:0] pri;
      logic [31:0] pulse;
      logic        st;
      logic        sp;
      logic        exp_err;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int waited;
      int pri, pulse, num, stop_c;

      tbl[0] = '{32'd10, 32'd0, 1'b1, 1'b1, 1'b0};                 // start+stop: stop wins, no error
      tbl[1] = '{32'd10, 32'd0, 1'b1, 1'b0, 1'b1};                 // zero pulse width
      tbl[2] = '{32'd10, 32'd0, 1'b0, 1'b0, 1'b1};                 // no start: error stays
      tbl[3] = '{32'd10, 32'd3, 1'b1, 1'b1, 1'b1};                 // valid cfg, stop wins
      tbl[4] = '{32'd5,  32'd5, 1'b1, 1'b0, 1'b1};                 // pri == pulse
      tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};  // pulse+1 overflow edge
      tbl[6] = '{32'd3,  32'd4, 1'b1, 1'b0, 1'b1};                 // pri < pulse

      repeat (3) @(negedge clk);
      check("reset_state", 0, 22'b0);
      rst_n = 1;

      run_burst("t1_basic", 10, 3, 2, -1, 0, 0);
      run_burst("t2_no_listen", 4, 3, 3, -1, 0, 0);

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         pri_in = tbl[i].pri; pulse_in = tbl[i].pulse; num_in = 16'd1;
         start = tbl[i].st; stop = tbl[i].sp;
         @(negedge clk);
         start = 0; stop = 0;
         @(negedge clk);
         check($sformatf("cfg_vec%0d", i), i, {5'b0, tbl[i].exp_err, prev_idx});
      end

      run_burst("t3_err_clear", 5, 4, 1, -1, 0, 0);
      run_burst("t4_stop_cont", 7, 2, 0, 23, 0, 1);
      run_burst("t5_cfg_change", 9, 4, 3, -1, 1, 0);

      // Async reset during LISTEN, then a clean restart.
      @(negedge clk);
      pri_in = 10; pulse_in = 3; num_in = 2; start = 1;
      @(negedge clk);
      start = 0;
      waited = 0;
      while (!rx_gate && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (!rx_gate) begin
         n_bad++;
         $display("FAIL rst_wait_listen got rx_gate=%b required=1 within 50 cycles", rx_gate);
      end
      @(posedge clk);
      #2 rst_n = 0;
      #1 check("rst_async", 0, 22'b0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("rst_hold", k, 22'b0);
      end
      rst_n = 1;
      prev_idx = '0;
      run_burst("t6_restart", 10, 3, 2, -1, 0, 0);

      for (int r = 0; r < 40; r++) begin
         pri   = int'($urandom_range(2, 20));
         pulse = int'($urandom_range(1, pri - 1));
         num   = int'($urandom_range(0, 4));
         if (num == 0) stop_c = int'($urandom_range(0, 5 * pri - 1));
         else if ($urandom_range(0, 1) == 1) stop_c = int'($urandom_range(0, num * pri - 1));
         else stop_c = -1;
         run_burst($sformatf("rnd%0d", r), pri, pulse, num, stop_c,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
